// File: rtl/debug_display_pkg.sv
// debug_display shared definitions
// seven-segment encodings and segment bit order
package debug_pkg;

    // segment bit positions inside a 7-bit digit (active high)
    typedef enum int unsigned {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F_BIT = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A_HEX = 7'h77;
    localparam logic [6:0] SEG_B_HEX = 7'h7C;
    localparam logic [6:0] SEG_C_HEX = 7'h39;
    localparam logic [6:0] SEG_D_HEX = 7'h5E;
    localparam logic [6:0] SEG_E_HEX = 7'h79;
    localparam logic [6:0] SEG_F_HEX = 7'h71;

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/debug_display_if.sv
// debug_display bus: sources, button, freeze in;
// digits, selection and held value out
interface debug_display_if #(
    parameter int N_SRC  = 4,
    parameter int DIGITS = 8
);
    localparam int WORD_W = 4 * DIGITS;
    localparam int SEL_W  = $clog2(N_SRC > 1 ? N_SRC : 2);

    logic [N_SRC*WORD_W-1:0] src_data;
    logic                    sel_btn;
    logic                    freeze;
    logic [DIGITS*7-1:0]     led;
    logic [SEL_W-1:0]        sel_idx;
    logic [WORD_W-1:0]       shown;

    modport master (
        output src_data, sel_btn, freeze,
        input  led, sel_idx, shown
    );

    modport slave (
        input  src_data, sel_btn, freeze,
        output led, sel_idx, shown
    );

endinterface

// File: rtl/debug_display_seg7_hex.sv
// seg7_hex: one hex nibble to seven-segment pattern
// purely combinational
module seg7_hex
    import debug_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // nibble lookup
    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A_HEX;
            4'hB: seg = SEG_B_HEX;
            4'hC: seg = SEG_C_HEX;
            4'hD: seg = SEG_D_HEX;
            4'hE: seg = SEG_E_HEX;
            4'hF: seg = SEG_F_HEX;
        endcase
    end

endmodule

// File: rtl/debug_display.sv
// debug_display: button-selected debug word shown on
// seven-segment digits, sampled slowly, freezable
module debug_display
    import debug_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DIGITS     = 8,
    parameter int UPDATE_DIV = 2000000,
    parameter int DEBOUNCE   = 240000,
    parameter int BLANK_LZ   = 1
) (
    input logic        clk,
    input logic        rst,
    debug_display_if.slave dbg
);

    localparam int WORD_W = 4 * DIGITS;
    localparam int SEL_W  = $clog2(N_SRC > 1 ? N_SRC : 2);
    localparam int TW     = $clog2(UPDATE_DIV + 1);
    localparam int DW     = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0]    T_LAST = TW'(UPDATE_DIV - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(DEBOUNCE - 1);
    localparam logic [SEL_W-1:0] S_LAST = SEL_W'(N_SRC - 1);

    logic                btn_s1;
    logic                btn_s2;
    logic                btn_deb;
    logic [DW-1:0]       deb_cnt;
    logic [TW-1:0]       tmr_cnt;
    logic                frz_q;
    logic                load_req;
    logic [SEL_W-1:0]    sel_q;
    logic [WORD_W-1:0]   shown_q;
    logic [DIGITS*7-1:0] led_q;
    logic [DIGITS*7-1:0] led_nxt;
    logic [DIGITS*7-1:0] led_rst;

    logic              tick;
    logic              press;
    logic              frz_fall;
    logic              load;
    logic [WORD_W-1:0] src_sel;

    assign tick     = (tmr_cnt == T_LAST);
    assign press    = btn_s2 && !btn_deb && (deb_cnt == D_LAST);
    assign frz_fall = frz_q && !dbg.freeze;
    assign load     = (load_req || frz_fall) && !dbg.freeze;
    assign src_sel  = dbg.src_data[int'(sel_q)*WORD_W +: WORD_W];

    // button synchroniser and debouncer
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_deb <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_s1 <= dbg.sel_btn;
            btn_s2 <= btn_s1;
            if (btn_s2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == D_LAST) begin
                btn_deb <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // free-running display update timer
    always_ff @(posedge clk) begin
        if (!rst) tmr_cnt <= '0;
        else      tmr_cnt <= tick ? '0 : tmr_cnt + 1'b1;
    end

    // source select and held-value load
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q    <= '0;
            load_req <= 1'b0;
            frz_q    <= 1'b0;
            shown_q  <= '0;
        end else begin
            frz_q    <= dbg.freeze;
            load_req <= tick || press;
            if (press)
                sel_q <= (sel_q == S_LAST) ? '0 : sel_q + 1'b1;
            if (load)
                shown_q <= src_sel;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        logic [6:0] seg;

        seg7_hex u_hex (
            .hex (shown_q[d*4 +: 4]),
            .seg (seg)
        );

        if (d == 0 || BLANK_LZ == 0) begin : g_show
            assign led_nxt[d*7 +: 7] = seg;
            assign led_rst[d*7 +: 7] = SEG_0;
        end else begin : g_blank
            assign led_nxt[d*7 +: 7] =
                (shown_q[WORD_W-1:d*4] == '0) ? SEG_BLANK : seg;
            assign led_rst[d*7 +: 7] = SEG_BLANK;
        end
    end

    // registered segment outputs
    always_ff @(posedge clk) begin
        if (!rst) led_q <= led_rst;
        else      led_q <= led_nxt;
    end

    assign dbg.led     = led_q;
    assign dbg.sel_idx = sel_q;
    assign dbg.shown   = shown_q;

endmodule

// File: tb/tb_debug_display.sv
// tb_debug_display: directed checks of selection,
// debounce, timed load, freeze and digit blanking
module tb_debug_display;

    localparam int N_SRC  = 4;
    localparam int DIGITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    debug_display_if #(.N_SRC(N_SRC), .DIGITS(DIGITS)) bus ();
    debug_display_if #(.N_SRC(N_SRC), .DIGITS(DIGITS)) bus_nb ();

    assign bus_nb.src_data = bus.src_data;
    assign bus_nb.sel_btn  = bus.sel_btn;
    assign bus_nb.freeze   = bus.freeze;

    debug_display #(
        .N_SRC(N_SRC), .DIGITS(DIGITS), .UPDATE_DIV(16),
        .DEBOUNCE(8), .BLANK_LZ(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dbg (bus)
    );

    debug_display #(
        .N_SRC(N_SRC), .DIGITS(DIGITS), .UPDATE_DIV(16),
        .DEBOUNCE(8), .BLANK_LZ(0)
    ) dut_nb (
        .clk (clk),
        .rst (rst),
        .dbg (bus_nb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int tmr_m  = 0;
    logic [31:0] srcs [4];

    // reference update-timer phase
    always @(posedge clk) begin
        if (!rst) tmr_m <= 0;
        else      tmr_m <= (tmr_m == 15) ? 0 : tmr_m + 1;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        srcs[k] = v;
        bus.src_data[k*32 +: 32] = v;
    endtask

    task automatic press_btn();
        bus.sel_btn = 1'b1;
        step(12);
        bus.sel_btn = 1'b0;
        step(12);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [55:0] led_of(input logic [31:0] w,
                                           input bit blank);
        logic [55:0] r;
        bit lead;
        r = '0;
        lead = blank;
        for (int d = 7; d >= 0; d--) begin
            if (w[d*4 +: 4] != 4'h0 || d == 0) lead = 1'b0;
            r[d*7 +: 7] = lead ? 7'h00 : seg_of(w[d*4 +: 4]);
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.src_data = '0;
        bus.sel_btn  = 1'b0;
        bus.freeze   = 1'b0;
        set_src(0, 32'h0000_00A5);
        set_src(1, 32'h00C0_FFEE);
        set_src(2, 32'h0000_0020);
        set_src(3, 32'h8000_0000);

        rst = 1'b0;
        step(3);
        check("rst_sel", 64'(bus.sel_idx), 64'(0));
        check("rst_shown", 64'(bus.shown), 64'(0));
        check("rst_led", 64'(bus.led), 64'(56'h3F));
        check("rst_led_nb", 64'(bus_nb.led), 64'({8{7'h3F}}));

        rst = 1'b1;
        step(16);
        check("pre_tick_shown", 64'(bus.shown), 64'(0));
        step(1);
        check("tick_shown", 64'(bus.shown), 64'(32'h0000_00A5));
        step(1);
        check("tick_led", 64'(bus.led), 64'(56'h3BED));
        check("tick_led_nb", 64'(bus_nb.led),
              64'({{6{7'h3F}}, 7'h77, 7'h6D}));

        bus.sel_btn = 1'b1;
        step(5);
        bus.sel_btn = 1'b0;
        step(15);
        check("glitch_sel", 64'(bus.sel_idx), 64'(0));

        bus.sel_btn = 1'b1;
        step(9);
        check("deb_early_sel", 64'(bus.sel_idx), 64'(0));
        step(1);
        check("deb_sel", 64'(bus.sel_idx), 64'(1));
        step(1);
        check("press_shown", 64'(bus.shown), 64'(32'h00C0_FFEE));
        step(9);
        bus.sel_btn = 1'b0;
        step(15);
        check("release_sel", 64'(bus.sel_idx), 64'(1));

        bus.sel_btn = 1'b1;
        step(5);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(4);
        bus.sel_btn = 1'b0;
        step(15);
        check("rst_mid_sel", 64'(bus.sel_idx), 64'(0));

        for (int i = 1; i <= 4; i++) begin
            press_btn();
            check("press_seq", 64'(bus.sel_idx), 64'(i % 4));
            check("press_src", 64'(bus.shown), 64'(srcs[i % 4]));
            check("press_led", 64'(bus.led),
                  64'(led_of(srcs[i % 4], 1'b1)));
        end

        set_src(0, 32'h1234_5678);
        step(20);
        check("pre_frz", 64'(bus.shown), 64'(32'h1234_5678));
        bus.freeze = 1'b1;
        step(2);
        set_src(0, 32'hDEAD_BEEF);
        step(50);
        check("frz_hold", 64'(bus.shown), 64'(32'h1234_5678));
        press_btn();
        check("frz_sel", 64'(bus.sel_idx), 64'(1));
        check("frz_hold_press", 64'(bus.shown), 64'(32'h1234_5678));
        press_btn();
        press_btn();
        press_btn();
        check("frz_sel_wrap", 64'(bus.sel_idx), 64'(0));
        bus.freeze = 1'b0;
        step(1);
        check("frz_fall_shown", 64'(bus.shown), 64'(32'hDEAD_BEEF));
        step(1);
        check("frz_fall_led", 64'(bus.led),
              64'({7'h5E, 7'h79, 7'h77, 7'h5E,
                   7'h7C, 7'h79, 7'h79, 7'h71}));

        set_src(0, 32'h0000_0000);
        step(20);
        check("zero_led", 64'(bus.led), 64'(56'h3F));
        check("zero_led_nb", 64'(bus_nb.led), 64'({8{7'h3F}}));

        set_src(0, 32'h0001_0000);
        step(20);
        check("lz_led", 64'(bus.led),
              64'({{3{7'h00}}, 7'h06, {4{7'h3F}}}));
        check("lz_led_nb", 64'(bus_nb.led),
              64'({{3{7'h3F}}, 7'h06, {4{7'h3F}}}));

        w = 0;
        while (tmr_m != 6 && w < 20) begin
            step(1);
            w++;
        end
        set_src(0, 32'h0BAD_F00D);
        bus.sel_btn = 1'b1;
        step(9);
        check("coin_pre", 64'(bus.shown), 64'(32'h0001_0000));
        step(1);
        check("coin_sel", 64'(bus.sel_idx), 64'(1));
        check("coin_hold", 64'(bus.shown), 64'(32'h0001_0000));
        step(1);
        check("coin_load", 64'(bus.shown), 64'(32'h00C0_FFEE));
        bus.sel_btn = 1'b0;
        step(15);
        check("coin_after", 64'(bus.shown), 64'(32'h00C0_FFEE));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
